// File: rtl/bateria_pkg.sv
// Shared types and default constants for the battery charge model.
package bateria_pkg;

   typedef enum logic [2:0] {
      DESLIGADO  = 3'd0,
      CARREGANDO = 3'd1,
      OCIOSO     = 3'd2,
      MOVENDO    = 3'd3,
      ESGOTADO   = 3'd4
   } estado_t;

   localparam int unsigned BAT_WIDTH     = 8;
   localparam int unsigned BAT_NIVEL_MAX = 200;
   localparam int unsigned BAT_TH_BAIXO  = 20;
   localparam int unsigned BAT_TH_MEDIO  = 80;
   localparam int unsigned BAT_TH_ALTO   = 150;
   localparam int unsigned BAT_TICK_DIV  = 1000;
   localparam int unsigned BAT_IDLE_DIV  = 4;

   // Opposite commands on the same axis cancel each other.
   function automatic logic movimento(input logic e, input logic d,
                                      input logic f, input logic a);
      return (e ^ d) | (f ^ a);
   endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module divisor_tick #(
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Tick on the last count; the counter wraps to zero on the same edge.
   always_comb begin
      tick  = (cnt_q == CW'(TICK_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/bateria_nivel.sv
// Battery charge model: saturating level, operating FSM and LED thermometer.
module bateria_nivel
   import bateria_pkg::*;
#(
   parameter int unsigned WIDTH     = BAT_WIDTH,
   parameter int unsigned NIVEL_MAX = BAT_NIVEL_MAX,
   parameter int unsigned TH_BAIXO  = BAT_TH_BAIXO,
   parameter int unsigned TH_MEDIO  = BAT_TH_MEDIO,
   parameter int unsigned TH_ALTO   = BAT_TH_ALTO,
   parameter int unsigned TICK_DIV  = BAT_TICK_DIV,
   parameter int unsigned IDLE_DIV  = BAT_IDLE_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             LD,
   input  logic             E,
   input  logic             D,
   input  logic             F,
   input  logic             A,
   input  logic             carregar,
   output logic             Baixo,
   output logic             Medio,
   output logic             Alto,
   output logic [WIDTH-1:0] nivel,
   output logic [2:0]       estado,
   output logic             vazia,
   output logic             cheia
);

   localparam int unsigned IW = (IDLE_DIV > 1) ? $clog2(IDLE_DIV) : 1;

   localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(NIVEL_MAX);
   localparam logic [IW-1:0]    IDLE_L = IW'(IDLE_DIV - 1);

   estado_t          estado_q, estado_d;
   logic [WIDTH-1:0] nivel_q, nivel_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic             tick;
   logic             mov;

   divisor_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_divisor_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign mov = movimento(E, D, F, A);

   // Level update driven by the registered state (the state being left).
   always_comb begin
      nivel_d = nivel_q;
      if (tick) begin
         unique case (estado_q)
            CARREGANDO: if (nivel_q != MAX_V) nivel_d = nivel_q + WIDTH'(1);
            MOVENDO:    if (nivel_q != '0)    nivel_d = nivel_q - WIDTH'(1);
            OCIOSO:     if (idle_q == IDLE_L && nivel_q != '0)
                           nivel_d = nivel_q - WIDTH'(1);
            default:    nivel_d = nivel_q;
         endcase
      end
   end

   // Next state looks at the level being written this edge, so the
   // drain to zero and the entry into ESGOTADO land on the same edge.
   always_comb begin
      estado_d = estado_q;
      if (estado_q == ESGOTADO) begin
         if (carregar && !LD) estado_d = CARREGANDO;
      end else if (!LD && carregar) begin
         estado_d = CARREGANDO;
      end else if (nivel_d == '0) begin
         estado_d = ESGOTADO;
      end else if (!LD) begin
         estado_d = DESLIGADO;
      end else if (mov) begin
         estado_d = MOVENDO;
      end else begin
         estado_d = OCIOSO;
      end
   end

   // Idle tick counter; it only lives while staying in OCIOSO.
   always_comb begin
      idle_d = idle_q;
      if (estado_q != OCIOSO || estado_d != OCIOSO) begin
         idle_d = '0;
      end else if (tick) begin
         idle_d = (idle_q == IDLE_L) ? '0 : idle_q + IW'(1);
      end
   end

   // State, level and idle counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= DESLIGADO;
         nivel_q  <= MAX_V;
         idle_q   <= '0;
      end else begin
         estado_q <= estado_d;
         nivel_q  <= nivel_d;
         idle_q   <= idle_d;
      end
   end

   // Flags and thermometer are straight compares of the registered level.
   always_comb begin
      nivel  = nivel_q;
      estado = estado_q;
      Baixo  = (nivel_q >= WIDTH'(TH_BAIXO));
      Medio  = (nivel_q >= WIDTH'(TH_MEDIO));
      Alto   = (nivel_q >= WIDTH'(TH_ALTO));
      vazia  = (nivel_q == '0);
      cheia  = (nivel_q == MAX_V);
   end

endmodule

// File: tb/tb_bateria_nivel.sv
// Directed bench for bateria_nivel with a 4-cycle tick and 4-tick idle drain.
module tb_bateria_nivel;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       LD = 1'b0, E = 1'b0, D = 1'b0, F = 1'b0, A = 1'b0;
   logic       carregar = 1'b0;
   logic       Baixo, Medio, Alto, vazia, cheia;
   logic [7:0] nivel;
   logic [2:0] estado;

   int n_chk  = 0;
   int n_pass = 0;

   bateria_nivel #(
      .WIDTH     (8),
      .NIVEL_MAX (200),
      .TH_BAIXO  (20),
      .TH_MEDIO  (80),
      .TH_ALTO   (150),
      .TICK_DIV  (4),
      .IDLE_DIV  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .LD       (LD),
      .E        (E),
      .D        (D),
      .F        (F),
      .A        (A),
      .carregar (carregar),
      .Baixo    (Baixo),
      .Medio    (Medio),
      .Alto     (Alto),
      .nivel    (nivel),
      .estado   (estado),
      .vazia    (vazia),
      .cheia    (cheia)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Advance n rising edges, then settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic ld, input logic e, input logic d,
                      input logic f, input logic c);
      LD = ld; E = e; D = d; F = f; A = 1'b0; carregar = c;
   endtask

   initial begin
      // Reset: one edge with rst high.
      step(1);
      rst = 1'b0;
      chk("rst_nivel", nivel, 200);
      chk("rst_estado", estado, 0);
      chk("rst_therm", {Alto, Medio, Baixo}, 3'b111);
      chk("rst_cheia", cheia, 1);
      chk("rst_vazia", vazia, 0);

      // Motion drain: first tick lands on the 4th edge after release.
      cmd(1, 0, 0, 1, 0);
      step(3);
      chk("mov_pre_tick", nivel, 200);
      chk("mov_estado", estado, 3);
      step(1);
      chk("mov_first_tick", nivel, 199);
      step(36);
      chk("mov_40cyc", nivel, 190);
      step(160);
      chk("mov_150", nivel, 150);
      chk("alto_at_150", Alto, 1);
      step(4);
      chk("mov_149", nivel, 149);
      chk("therm_149", {Alto, Medio, Baixo}, 3'b011);

      // Opposite commands cancel: idle drain of 1 per 16 cycles.
      cmd(1, 1, 1, 0, 0);
      step(1);
      chk("idle_estado", estado, 2);
      step(14);
      chk("idle_hold", nivel, 149);
      step(1);
      chk("idle_drop1", nivel, 148);
      step(16);
      chk("idle_drop2", nivel, 147);

      // Leave idle with two ticks counted; counter must clear.
      step(8);
      cmd(1, 0, 0, 1, 0);
      step(1);
      chk("resume_estado", estado, 3);
      step(3);
      chk("resume_drain", nivel, 146);
      cmd(1, 1, 1, 0, 0);
      step(8);
      chk("idle_cleared_hold", nivel, 146);
      step(8);
      chk("idle_cleared_drop", nivel, 145);

      // Exhaustion.
      cmd(1, 0, 0, 1, 0);
      step(576);
      chk("exh_nivel1", nivel, 1);
      chk("exh_baixo_low", Baixo, 0);
      step(3);
      chk("exh_pre_estado", estado, 3);
      step(1);
      chk("exh_nivel0", nivel, 0);
      chk("exh_estado", estado, 4);
      chk("exh_vazia", vazia, 1);
      chk("exh_therm", {Alto, Medio, Baixo}, 3'b000);

      // Sticky ESGOTADO.
      cmd(0, 0, 0, 0, 0);
      step(5);
      chk("sticky_off", estado, 4);
      cmd(1, 1, 0, 0, 0);
      step(5);
      chk("sticky_mov", estado, 4);
      chk("sticky_nivel", nivel, 0);
      cmd(1, 1, 0, 0, 1);
      step(5);
      chk("sticky_ld_chg", estado, 4);

      // Charging.
      cmd(0, 0, 0, 0, 1);
      step(1);
      chk("chg_estado", estado, 1);
      chk("chg_exit_tick", nivel, 0);
      step(76);
      chk("chg_19", nivel, 19);
      chk("chg_baixo19", Baixo, 0);
      step(4);
      chk("chg_20", nivel, 20);
      chk("chg_baixo20", Baixo, 1);
      step(720);
      chk("chg_full", nivel, 200);
      chk("chg_cheia", cheia, 1);
      step(12);
      chk("chg_sat", nivel, 200);
      chk("chg_sat_estado", estado, 1);

      // Power on while docked: no charging, idle state.
      cmd(1, 0, 0, 0, 1);
      step(1);
      chk("ld_chg_estado", estado, 2);
      chk("ld_chg_nivel", nivel, 200);

      // Drain to 57, dock, then reset mid-charge.
      cmd(1, 0, 0, 1, 1);
      step(1);
      chk("ld_chg_mov", estado, 3);
      step(570);
      chk("drain_57", nivel, 57);
      cmd(0, 0, 0, 0, 1);
      step(1);
      chk("midchg_estado", estado, 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("midrst_nivel", nivel, 200);
      chk("midrst_estado", estado, 0);
      chk("midrst_cheia", cheia, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
